// File: rtl/audio_frame_reader.sv
// Read side of the audio CDC FIFO: pops samples into a 2-entry skid buffer and emits a framed valid/ready stream.
// Latency: fifo_rd_en in the first RUN cycle, m_valid the next cycle (FIFO data bypasses an empty buffer).
// Backpressure: m_ready low holds the head sample; reads are throttled so at most 2 samples are buffered or in flight.
// Ports: rd_clk/rd_rst_n clock and async active-low reset; en run request (stops on a frame boundary);
//        sync_clr synchronous flush; fifo_rd_en/fifo_rd_data/fifo_empty FIFO read port (1-cycle read latency);
//        m_valid/m_ready/m_data/m_first/m_last output stream; frame_done pulse on the m_last handshake;
//        busy while a frame is in progress or samples are held.
module audio_frame_reader #(
  parameter int DATA_WIDTH = 16,
  parameter int FRAME_LEN  = 1024,
  parameter int CNT_W      = 10,
  parameter bit SWAP_BYTES = 1'b0
) (
  input  logic                  rd_clk,
  input  logic                  rd_rst_n,
  input  logic                  en,
  input  logic                  sync_clr,
  output logic                  fifo_rd_en,
  input  logic [DATA_WIDTH-1:0] fifo_rd_data,
  input  logic                  fifo_empty,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_first,
  output logic                  m_last,
  output logic                  frame_done,
  output logic                  busy
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(FRAME_LEN - 1);
  localparam logic [CNT_W+1:0] FRAME_LEN_W = (CNT_W+2)'(FRAME_LEN);

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [1:0]            occ_q, occ_d;
  logic                  pending_q, pending_d;
  logic [DATA_WIDTH-1:0] buf0_q, buf0_d;
  logic [DATA_WIDTH-1:0] buf1_q, buf1_d;

  logic [DATA_WIDTH-1:0] wr_dat;
  logic                  pop;
  logic                  push;
  logic                  run;
  logic                  room;
  logic                  frame_ok;
  logic [2:0]            inflight;
  logic [CNT_W+1:0]      frame_used;
  logic [1:0]            occ_shift;
  logic [CNT_W-1:0]      cnt_next;

  generate
    if (SWAP_BYTES) begin : g_swap
      assign wr_dat = {fifo_rd_data[7:0], fifo_rd_data[DATA_WIDTH-1:8]};
    end else begin : g_noswap
      assign wr_dat = fifo_rd_data;
    end
  endgenerate

  always_comb begin
    // Head of stream: buffer head if any, else the FIFO word arriving this cycle.
    // A flush cycle presents nothing so the in-flight word can never be accepted.
    m_valid    = !sync_clr && ((occ_q != 2'd0) || pending_q);
    m_data     = '0;
    if (m_valid) begin
      m_data = (occ_q != 2'd0) ? buf0_q : wr_dat;
    end
    m_first    = m_valid && (cnt_q == '0);
    m_last     = m_valid && (cnt_q == CNT_LAST);
    pop        = m_valid && m_ready;
    frame_done = pop && m_last;
    busy       = (cnt_q != '0) || (occ_q != 2'd0) || pending_q;

    run        = (state_q != IDLE);
    inflight   = {1'b0, occ_q} + {2'b00, pending_q} - {2'b00, pop};
    room       = (inflight < 3'd2);
    // With en low, only read what the current frame still needs: cnt plus
    // everything held or in flight must stay below FRAME_LEN.
    frame_used = {2'b00, cnt_q} + {{CNT_W{1'b0}}, occ_q} + {{(CNT_W+1){1'b0}}, pending_q};
    frame_ok   = en || ((cnt_q != '0) && (frame_used < FRAME_LEN_W));
    fifo_rd_en = run && !fifo_empty && !sync_clr && room && frame_ok;

    // Skid buffer: shift on pop, then append the returning word at the tail.
    // A word popped straight off the bypass path is never stored.
    buf0_d    = buf0_q;
    buf1_d    = buf1_q;
    occ_shift = occ_q;
    if (pop && (occ_q != 2'd0)) begin
      buf0_d    = buf1_q;
      occ_shift = occ_q - 2'd1;
    end
    push  = pending_q && !(pop && (occ_q == 2'd0));
    occ_d = occ_shift;
    if (push) begin
      if (occ_shift == 2'd0) begin
        buf0_d = wr_dat;
      end else begin
        buf1_d = wr_dat;
      end
      occ_d = occ_shift + 2'd1;
    end
    pending_d = fifo_rd_en;

    cnt_next = cnt_q;
    if (pop) begin
      cnt_next = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
    end
    cnt_d = cnt_next;

    state_d = state_q;
    case (state_q)
      IDLE:  if (en) state_d = RUN;
      // Judge the boundary after this cycle's handshake, so a stop that
      // coincides with the last handshake goes straight to IDLE.
      RUN:   if (!en) state_d = (cnt_next == '0) ? IDLE : DRAIN;
      DRAIN: begin
        if (en) begin
          state_d = RUN;
        end else if (frame_done) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (sync_clr) begin
      occ_d     = 2'd0;
      pending_d = 1'b0;
      cnt_d     = '0;
      state_d   = IDLE;
    end
  end

  always_ff @(posedge rd_clk or negedge rd_rst_n) begin
    if (!rd_rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      occ_q     <= 2'd0;
      pending_q <= 1'b0;
      buf0_q    <= '0;
      buf1_q    <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      occ_q     <= occ_d;
      pending_q <= pending_d;
      buf0_q    <= buf0_d;
      buf1_q    <= buf1_d;
    end
  end

endmodule

// File: tb/tb_audio_frame_reader.sv
// Bench for audio_frame_reader with FRAME_LEN=4 and byte swap enabled.
// Latency: n/a (bench); a behavioural 1-cycle-latency FIFO feeds the DUT.
// Backpressure: m_ready driven constant or randomly per scenario.
module tb_audio_frame_reader;

  localparam int DW = 16;
  localparam int FL = 4;
  localparam int CW = 2;

  typedef struct packed {
    logic [15:0] dat;
    logic        first;
    logic        last;
  } exp_t;

  logic          rd_clk = 1'b0;
  logic          rd_rst_n;
  logic          en;
  logic          sync_clr;
  logic          fifo_rd_en;
  logic [DW-1:0] fifo_rd_data;
  logic          fifo_empty;
  logic          m_valid;
  logic          m_ready;
  logic [DW-1:0] m_data;
  logic          m_first;
  logic          m_last;
  logic          frame_done;
  logic          busy;

  exp_t        sb[$];
  logic [15:0] fifo_q[$];
  int          n_vec = 0;
  int          n_err = 0;
  int          ld_pos = 0;
  int          reads = 0;
  int          accepts = 0;
  logic        s_valid, s_rd, s_busy, s_hs;
  logic [15:0] s_dat;
  logic [15:0] head;

  always #5 rd_clk = ~rd_clk;

  audio_frame_reader #(
    .DATA_WIDTH(DW),
    .FRAME_LEN (FL),
    .CNT_W     (CW),
    .SWAP_BYTES(1'b1)
  ) dut (
    .rd_clk      (rd_clk),
    .rd_rst_n    (rd_rst_n),
    .en          (en),
    .sync_clr    (sync_clr),
    .fifo_rd_en  (fifo_rd_en),
    .fifo_rd_data(fifo_rd_data),
    .fifo_empty  (fifo_empty),
    .m_valid     (m_valid),
    .m_ready     (m_ready),
    .m_data      (m_data),
    .m_first     (m_first),
    .m_last      (m_last),
    .frame_done  (frame_done),
    .busy        (busy)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] swap16(input logic [15:0] w);
    return {w[7:0], w[15:8]};
  endfunction

  // Queue a word in the FIFO model and its expected output in the scoreboard.
  task automatic load(input logic [15:0] w);
    exp_t e;
    e.dat   = swap16(w);
    e.first = ((ld_pos % FL) == 0);
    e.last  = ((ld_pos % FL) == FL - 1);
    sb.push_back(e);
    fifo_q.push_back(w);
    ld_pos++;
    fifo_empty = 1'b0;
  endtask

  task automatic flush();
    sb.delete();
    fifo_q.delete();
    ld_pos     = 0;
    reads      = 0;
    accepts    = 0;
    fifo_empty = 1'b1;
  endtask

  // One clock: sample/check at negedge, then apply FIFO read effects at posedge+1.
  task automatic step();
    @(negedge rd_clk);
    s_valid = m_valid;
    s_rd    = fifo_rd_en;
    s_busy  = busy;
    s_hs    = m_valid && m_ready;
    s_dat   = m_data;
    chk("rd_en_while_empty", 32'(fifo_rd_en && fifo_empty), 32'(0));
    if (m_valid) begin
      if (sb.size() == 0) begin
        chk("unexpected_valid", 32'(m_valid), 32'(0));
      end else begin
        chk("m_data", 32'(m_data), 32'(sb[0].dat));
        chk("m_first", 32'(m_first), 32'(sb[0].first));
        chk("m_last", 32'(m_last), 32'(sb[0].last));
        if (m_ready) begin
          chk("frame_done", 32'(frame_done), 32'(sb[0].last));
          void'(sb.pop_front());
          accepts++;
        end
      end
    end else begin
      chk("idle_flags", 32'({m_first, m_last, frame_done}), 32'(0));
    end
    if (fifo_rd_en) reads++;
    chk("outstanding_le2", 32'((reads - accepts) <= 2), 32'(1));
    @(posedge rd_clk);
    #1;
    if (s_rd && fifo_q.size() != 0) fifo_rd_data = fifo_q.pop_front();
    fifo_empty = (fifo_q.size() == 0);
  endtask

  task automatic run_until(input int budget, input string tag);
    for (int i = 0; i < budget; i++) begin
      if (sb.size() == 0) break;
      step();
    end
    chk({tag, "_drained"}, 32'(sb.size()), 32'(0));
  endtask

  task automatic do_reset();
    rd_rst_n     = 1'b0;
    en           = 1'b0;
    sync_clr     = 1'b0;
    m_ready      = 1'b0;
    fifo_rd_data = '0;
    flush();
    repeat (2) @(posedge rd_clk);
    #1;
    rd_rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    rd_rst_n     = 1'b0;
    en           = 1'b0;
    sync_clr     = 1'b0;
    m_ready      = 1'b0;
    fifo_rd_data = '0;
    fifo_empty   = 1'b1;
    repeat (2) @(posedge rd_clk);
    #1;
    chk("reset_outputs", 32'({m_valid, m_first, m_last, frame_done, busy, fifo_rd_en, m_data}), 32'(0));
    rd_rst_n = 1'b1;

    // Back-to-back frames, first-read latency.
    for (int w = 1; w <= 8; w++) load(16'(w));
    m_ready = 1'b1;
    repeat (2) begin
      step();
      chk("t2_hold_valid", 32'(s_valid), 32'(0));
      chk("t2_hold_rd", 32'(s_rd), 32'(0));
    end
    en = 1'b1;
    step();
    step();
    chk("t2_c0_rd_en", 32'(s_rd), 32'(1));
    chk("t2_c0_valid", 32'(s_valid), 32'(0));
    for (int i = 0; i < 8; i++) begin
      step();
      chk("t2_back_to_back", 32'(s_hs), 32'(1));
    end
    en = 1'b0;
    repeat (2) step();
    chk("t2_busy_end", 32'(s_busy), 32'(0));
    chk("t2_sb_empty", 32'(sb.size()), 32'(0));

    // Frame-aligned stop after the second handshake.
    do_reset();
    for (int w = 1; w <= 8; w++) load(16'(w));
    m_ready = 1'b1;
    en      = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      if (accepts == 2) break;
    end
    chk("t4_two_accepted", 32'(accepts), 32'(2));
    en = 1'b0;
    repeat (6) step();
    head = (fifo_q.size() != 0) ? fifo_q[0] : 16'h0;
    chk("t4_accepted", 32'(accepts), 32'(4));
    chk("t4_fifo_left", 32'(fifo_q.size()), 32'(4));
    chk("t4_fifo_head", 32'(head), 32'h0005);
    chk("t4_valid", 32'(s_valid), 32'(0));
    chk("t4_busy", 32'(s_busy), 32'(0));
    en = 1'b1;
    run_until(40, "t4_resume");
    en = 1'b0;
    repeat (2) step();

    // FIFO underflow mid-frame.
    do_reset();
    load(16'h0001);
    load(16'h0002);
    m_ready = 1'b1;
    en      = 1'b1;
    repeat (6) step();
    chk("t5_two_out", 32'(accepts), 32'(2));
    chk("t5_valid_low", 32'(s_valid), 32'(0));
    chk("t5_busy_held", 32'(s_busy), 32'(1));
    chk("t5_cnt_held", 32'(dut.cnt_q), 32'(2));
    load(16'h0003);
    run_until(10, "t5_refill");
    load(16'h0004);
    run_until(10, "t5_last");
    en = 1'b0;
    repeat (2) step();
    chk("t5_busy_end", 32'(s_busy), 32'(0));

    // Random backpressure over 256 samples.
    do_reset();
    for (int i = 0; i < 256; i++) load(16'($urandom));
    en = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if (sb.size() == 0) break;
      m_ready = 1'($urandom_range(0, 1));
      step();
    end
    chk("t3_drained", 32'(sb.size()), 32'(0));
    chk("t3_fifo_empty", 32'(fifo_q.size()), 32'(0));
    chk("t3_count", 32'(accepts), 32'(256));
    en      = 1'b0;
    m_ready = 1'b1;
    repeat (2) step();

    // Asynchronous reset mid-stream, then restart on a fresh frame.
    do_reset();
    for (int i = 0; i < 20; i++) load(16'(16'h0100 + i));
    m_ready = 1'b1;
    en      = 1'b1;
    repeat (6) step();
    chk("t1_prereset_valid", 32'(m_valid), 32'(1));
    #2;
    rd_rst_n = 1'b0;
    #1;
    chk("t1_async_reset", 32'({m_valid, m_first, m_last, frame_done, busy, fifo_rd_en, m_data}), 32'(0));
    en = 1'b0;
    flush();
    fifo_rd_data = '0;
    @(posedge rd_clk);
    #1;
    rd_rst_n = 1'b1;
    for (int i = 0; i < 4; i++) load(16'(16'h0200 + i));
    repeat (3) begin
      step();
      chk("t1_wait_en_valid", 32'(s_valid), 32'(0));
      chk("t1_wait_en_rd", 32'(s_rd), 32'(0));
    end
    en = 1'b1;
    run_until(20, "t1_restart");
    en = 1'b0;
    repeat (2) step();

    // Byte swap and flush with a read in flight.
    do_reset();
    load(16'h1234);
    load(16'hABCD);
    m_ready = 1'b1;
    en      = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      if (accepts == 1) break;
    end
    chk("t6_first_accepted", 32'(accepts), 32'(1));
    chk("t6_swap", 32'(s_dat), 32'h3412);
    chk("t6_pending", 32'(dut.pending_q), 32'(1));
    sync_clr = 1'b1;
    step();
    chk("t6_clr_valid", 32'(s_valid), 32'(0));
    chk("t6_clr_rd", 32'(s_rd), 32'(0));
    sync_clr = 1'b0;
    flush();
    repeat (3) step();
    chk("t6_after_valid", 32'(s_valid), 32'(0));
    chk("t6_after_busy", 32'(s_busy), 32'(0));
    chk("t6_after_data", 32'(m_data), 32'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
